// File: rtl/piano_song_player.sv
// piano_song_player: plays the stored 28-note piano melody on note_out.
// Each note is held for NOTE_CYCLES clocks.
// After each note, note_out is silent (code 0) for GAP_CYCLES clocks.
// This block feeds the note display and tone generator as the "listen first" demo.
module piano_song_player #(
  parameter int SONG_LEN    = 28,
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic [2:0] note_out,
  output logic [4:0] note_idx,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [4:0]    LAST_IDX  = 5'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    note_n;
  logic [4:0]    idx_n;
  logic          busy_n, done_n;

  // Melody ROM, shared with the piano game. Every real entry is nonzero.
  // A zero note code means silence.
  function automatic logic [2:0] rom_note(input logic [4:0] idx);
    case (idx)
      5'd0,  5'd1:  rom_note = 3'd1;
      5'd2,  5'd3:  rom_note = 3'd5;
      5'd4,  5'd5:  rom_note = 3'd6;
      5'd6:         rom_note = 3'd5;
      5'd7,  5'd8:  rom_note = 3'd4;
      5'd9,  5'd10: rom_note = 3'd3;
      5'd11, 5'd12: rom_note = 3'd2;
      5'd13:        rom_note = 3'd1;
      5'd14, 5'd15: rom_note = 3'd5;
      5'd16, 5'd17: rom_note = 3'd4;
      5'd18, 5'd19: rom_note = 3'd3;
      5'd20:        rom_note = 3'd2;
      5'd21, 5'd22: rom_note = 3'd5;
      5'd23, 5'd24: rom_note = 3'd4;
      5'd25, 5'd26: rom_note = 3'd3;
      5'd27:        rom_note = 3'd2;
      default:      rom_note = 3'd0;
    endcase
  endfunction

  // Next-state and next-output logic. Abort overrides start and timer expiry.
  always_comb begin
    state_n = state;
    timer_n = timer;
    note_n  = note_out;
    idx_n   = note_idx;
    busy_n  = busy;
    done_n  = done;
    if (abort) begin
      state_n = IDLE;
      timer_n = '0;
      note_n  = 3'd0;
      idx_n   = 5'd0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n = NOTE;
            timer_n = '0;
            idx_n   = 5'd0;
            note_n  = rom_note(5'd0);
            busy_n  = 1'b1;
            done_n  = 1'b0;
          end
        end
        NOTE: begin
          if (timer == NOTE_LAST) begin
            state_n = GAP;
            timer_n = '0;
            note_n  = 3'd0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            timer_n = '0;
            if (note_idx < LAST_IDX) begin
              state_n = NOTE;
              idx_n   = note_idx + 5'd1;
              note_n  = rom_note(note_idx + 5'd1);
            end else begin
              state_n = DONE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end else begin
            timer_n = timer + TW'(1);
          end
        end
      endcase
    end
  end

  // Registered state and outputs, with synchronous reset to the idle condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      note_out <= 3'd0;
      note_idx <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      note_out <= note_n;
      note_idx <= idx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_piano_song_player.sv
// Testbench for piano_song_player, using short note and gap lengths.
// Directed steps and random steps are checked against a timeline model of the song.
module tb_piano_song_player;

  localparam int NC   = 3;
  localparam int GC   = 2;
  localparam int LEN  = 28;
  localparam int SLOT = NC + GC;
  localparam int SONG = LEN * SLOT;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [2:0] note_out;
  logic [4:0] note_idx;
  logic       busy, done;

  int vectors = 0;
  int miscompares = 0;

  int melody [LEN] = '{1,1,5,5,6,6,5, 4,4,3,3,2,2,1, 5,5,4,4,3,3,2, 5,5,4,4,3,3,2};

  // The model keeps only whether a song is in progress and how far in it is.
  // It also remembers whether the last song finished.
  bit playing  = 1'b0;
  bit finished = 1'b0;
  int elapsed  = 0;

  piano_song_player #(.SONG_LEN(LEN), .NOTE_CYCLES(NC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .note_out(note_out), .note_idx(note_idx), .busy(busy), .done(done)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    int en, ei, eb, ed;
    en = 0; ei = 0; eb = 0; ed = 0;
    if (playing) begin
      ei = elapsed / SLOT;
      en = ((elapsed % SLOT) < NC) ? melody[ei] : 0;
      eb = 1;
    end else if (finished) begin
      ei = LEN - 1;
      ed = 1;
    end
    vectors += 4;
    assert (int'(note_out) === en) else begin
      miscompares++;
      $error("[TB] FAIL %s note_out got=%0d want=%0d (t=%0t)", tag, note_out, en, $time);
    end
    assert (int'(note_idx) === ei) else begin
      miscompares++;
      $error("[TB] FAIL %s note_idx got=%0d want=%0d (t=%0t)", tag, note_idx, ei, $time);
    end
    assert (int'(busy) === eb) else begin
      miscompares++;
      $error("[TB] FAIL %s busy got=%0d want=%0d (t=%0t)", tag, busy, eb, $time);
    end
    assert (int'(done) === ed) else begin
      miscompares++;
      $error("[TB] FAIL %s done got=%0d want=%0d (t=%0t)", tag, done, ed, $time);
    end
  endtask

  // Drive one cycle of inputs and update the model at the clock edge.
  // The outputs are then checked 1 time unit after the edge.
  task automatic applyStimulus(input bit r, input bit s, input bit a, input string tag);
    reset = r; start = s; abort = a;
    @(posedge clk);
    if (r || a) begin
      playing = 1'b0; finished = 1'b0; elapsed = 0;
    end else if (playing) begin
      elapsed++;
      if (elapsed == SONG) begin
        playing = 1'b0; finished = 1'b1;
      end
    end else if (s) begin
      playing = 1'b1; finished = 1'b0; elapsed = 0;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;

    // Reset and idle.
    applyStimulus(1, 0, 0, "reset0");
    applyStimulus(1, 0, 0, "reset1");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, "idle");

    // Full playback from a one-cycle start pulse, running into DONE.
    applyStimulus(0, 1, 0, "start_full");
    for (int i = 0; i < SONG + 8; i++) applyStimulus(0, 0, 0, "full_play");

    // Abort while note 4 is sounding, then restart from note 0.
    applyStimulus(0, 1, 0, "start_abort");
    for (int i = 0; i < 4 * SLOT + 1; i++) applyStimulus(0, 0, 0, "to_note4");
    applyStimulus(0, 0, 1, "abort_note4");
    applyStimulus(0, 1, 0, "restart_after_abort");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, "after_abort");

    // Start and abort together leaves the player idle.
    applyStimulus(0, 0, 1, "abort_clear");
    applyStimulus(0, 1, 1, "start_and_abort");
    applyStimulus(0, 0, 0, "still_idle");

    // A start pulse during the gap after note 10 is ignored.
    applyStimulus(0, 1, 0, "start_gap");
    for (int i = 0; i < 10 * SLOT + NC; i++) applyStimulus(0, 0, 0, "to_gap10");
    applyStimulus(0, 1, 0, "start_in_gap");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, "note11");

    // Holding start keeps the song looping through DONE.
    for (int i = 0; i < 2 * SONG + 20; i++) applyStimulus(0, 1, 0, "loop");

    // Reset during the gap after note 20 returns every output to its reset value.
    applyStimulus(0, 0, 1, "abort_before_reset");
    applyStimulus(0, 1, 0, "start_reset");
    for (int i = 0; i < 20 * SLOT + NC; i++) applyStimulus(0, 0, 0, "to_gap20");
    applyStimulus(1, 0, 0, "reset_gap20");
    applyStimulus(0, 0, 0, "after_reset");

    // Random start/abort/reset activity.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 99) == 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piano_song_player.md
Name: piano_song_player

Overview:
- Demo/playback counterpart of the piano game. The game checks player switch input against a stored melody; this block drives that same melody out.
- Steps through the internal 28-note song ROM and presents one note code at a time on `note_out`. Each note is followed by a silent gap (code 0), using the same note/zero encoding the game consumes.
- Feeds the board note display and tone generator, and acts as the "listen first" mode before a game round.

Parameters:
- SONG_LEN, 28, number of notes in the ROM. Legal range 1..32.
- NOTE_CYCLES, 25000000, clock cycles each note is held on `note_out`. Must be ≥1.
- GAP_CYCLES, 5000000, clock cycles of silence after each note. Must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  level; begins playback from note 0 when sampled high in IDLE or DONE
- abort  input  1  level; stops playback and returns to IDLE
- note_out  output  3  current note code: 1=C 2=D 3=E 4=F 5=G 6=A 7=B, 0=silence
- note_idx  output  5  index of the current or most recent note, 0..SONG_LEN-1
- busy  output  1  high in NOTE and GAP
- done  output  1  high in DONE

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, note_out=0, note_idx=0, busy=0, done=0, timer=0.
- ROM is a fixed constant, indices 0..27:
  - 0..6: 1 1 5 5 6 6 5
  - 7..13: 4 4 3 3 2 2 1
  - 14..20: 5 5 4 4 3 3 2
  - 21..27: 5 5 4 4 3 3 2
  - Every entry is nonzero.
- States: IDLE, NOTE, GAP, DONE.
- IDLE:
  - start=1 and abort=0 at edge k → after edge k: state=NOTE, note_idx=0, note_out=ROM[0], busy=1, timer=0.
  - Latency from start sampled to first note visible is 1 edge.
- NOTE:
  - note_out=ROM[note_idx].
  - timer increments each cycle.
  - When timer==NOTE_CYCLES-1: next state=GAP, note_out=0, timer=0.
  - Each note is visible for exactly NOTE_CYCLES cycles.
- GAP:
  - note_out=0 for exactly GAP_CYCLES cycles.
  - At timer==GAP_CYCLES-1:
    - if note_idx<SONG_LEN-1: note_idx+1, next state=NOTE, note_out=ROM[note_idx+1].
    - else: next state=DONE, busy=0, done=1.
- DONE:
  - Holds note_out=0 and note_idx=SONG_LEN-1.
  - start=1 → restart exactly as from IDLE.
- abort:
  - abort=1 in any state → next state=IDLE, note_out=0, busy=0, done=0, note_idx=0, timer=0.
  - abort has priority over start and over timer expiry in the same cycle.
- start while busy (NOTE/GAP) is ignored; playback is not restarted.
- start held high continuously: DONE restarts immediately on the next edge (the song loops).
- reset mid-song: same result as abort, on the next edge.
- Width rules:
  - timer width = clog2(max(NOTE_CYCLES,GAP_CYCLES)).
  - Comparisons are unsigned.
  - note_idx never exceeds SONG_LEN-1; no wrap-around.
- Total song length from start edge to done=1 is SONG_LEN×(NOTE_CYCLES+GAP_CYCLES) cycles.

Test Plan:
- Reset/idle (NOTE_CYCLES=3, GAP_CYCLES=2): hold reset 2 cycles, release, start=0 for 10 cycles → note_out=0, busy=0, done=0, note_idx=0 throughout.
- Full playback (NOTE_CYCLES=3, GAP_CYCLES=2): pulse start 1 cycle.
  - Sampled note_out sequence begins 1,1,1,0,0,1,1,1,0,0,5,5,5,0,0…
  - note_idx steps 0→27.
  - done=1 exactly 140 cycles after the start edge; busy=0 from then on.
- Abort mid-note: abort=1 while note_idx=4 in NOTE → next cycle state IDLE, note_out=0, note_idx=0, busy=0. A following start plays from ROM[0]=1.
- Priority: start=1 and abort=1 together in IDLE → stays IDLE. start pulsed during GAP at note_idx=10 → sequence unaffected; note_idx=11 next, note_out=2.
- Restart/loop: in DONE, hold start=1 → next edge note_out=1, note_idx=0, done=0, busy=1. Song repeats identically.
- Reset mid-gap: reset=1 during GAP at note_idx=20 → after the edge, all outputs equal their reset values.
